// File: rtl/prog_run_sequencer.sv
// prog_run_sequencer: launches a table of program start addresses back to back and records per-program results.
// Define SEQ_TIMEOUT_EN to abort a program's RUN after TIMEOUT_CYCLES without a done edge.
module prog_run_sequencer #(
   parameter int NUM_PROGS = 3,
   parameter int ADDR_W = 8,
   parameter int CNT_W = 16,
   parameter int TIMEOUT_CYCLES = 50000,
   localparam int IW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic              go,
   input  logic              wr_en,
   input  logic [IW-1:0]     wr_idx,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [IW-1:0]     rd_idx,
   output logic              start,
   output logic [ADDR_W-1:0] start_addr,
   input  logic              done,
   input  logic              halt,
   output logic [CNT_W-1:0]  rd_cycles,
   output logic              rd_halted,
   output logic              rd_timeout,
   output logic              busy,
   output logic              batch_done
);
   localparam logic [2:0] IDLE = 3'd0, LAUNCH = 3'd1, RUN = 3'd2, RECORD = 3'd3, FINISH = 3'd4;
`ifdef SEQ_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif
   logic [2:0] state;
   logic [IW-1:0] idx;
   logic [ADDR_W-1:0] tbl [NUM_PROGS];
   logic [CNT_W-1:0] res_cnt [NUM_PROGS];
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [NUM_PROGS-1:0] res_halt, res_to;
   logic done_q, halted, timed_out, edge_seen, to_hit, last, idle, wr_ok, rd_ok;

   assign idle = (state == IDLE) || (state == FINISH);
   assign last = int'(idx) == NUM_PROGS - 1;
   assign wr_ok = int'(wr_idx) < NUM_PROGS;
   assign rd_ok = int'(rd_idx) < NUM_PROGS;
   assign cnt_inc = &cnt ? cnt : cnt + 1'b1;
   // done_q tracks done through LAUNCH so a level held over from the previous program is not an edge
   assign edge_seen = done & ~done_q;
   assign to_hit = TO_EN & ~edge_seen & (int'(cnt_inc) == TIMEOUT_CYCLES);

   assign start = state == LAUNCH;
   assign start_addr = tbl[idx];
   assign busy = ~idle;
   assign batch_done = state == FINISH;
   assign rd_cycles = rd_ok ? res_cnt[rd_idx] : '0;
   assign rd_halted = rd_ok & res_halt[rd_idx];
   assign rd_timeout = TO_EN & rd_ok & res_to[rd_idx];

   always_ff @(posedge CLK or posedge Reset)
      if (Reset) begin
         state <= IDLE;
         idx <= '0;
         cnt <= '0;
         done_q <= 1'b0;
         halted <= 1'b0;
         timed_out <= 1'b0;
         res_halt <= '0;
         res_to <= '0;
         for (int i = 0; i < NUM_PROGS; i++) begin
            tbl[i] <= '0;
            res_cnt[i] <= '0;
         end
      end else begin
         if (idle && wr_en && wr_ok) tbl[wr_idx] <= wr_addr;
         case (state)
            LAUNCH: begin
               cnt <= '0;
               halted <= 1'b0;
               timed_out <= 1'b0;
               done_q <= done;
               state <= RUN;
            end
            RUN: begin
               cnt <= cnt_inc;
               done_q <= done;
               if (halt) halted <= 1'b1;
               if (edge_seen || to_hit) begin
                  timed_out <= to_hit;
                  state <= RECORD;
               end
            end
            RECORD: begin
               res_cnt[idx] <= cnt;
               res_halt[idx] <= halted;
               res_to[idx] <= timed_out;
               done_q <= 1'b0;
               idx <= last ? idx : idx + 1'b1;
               state <= last ? FINISH : LAUNCH;
            end
            IDLE, FINISH: if (go) begin
               idx <= '0;
               res_halt <= '0;
               res_to <= '0;
               state <= LAUNCH;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_prog_run_sequencer.sv
// tb_prog_run_sequencer: randomized batches checked every cycle against a timeline model built from done/halt waveforms.
module tb_prog_run_sequencer;
   localparam int N = 3, AW = 8, CW = 16, ML = 128;
`ifdef SEQ_TIMEOUT_EN
   localparam int TO = 100;
`else
   localparam int TO = 50000;
`endif
   logic CLK = 0, Reset = 1, go = 0, wr_en = 0, done = 0, halt = 0;
   logic [1:0] wr_idx = 0, rd_idx = 0;
   logic [AW-1:0] wr_addr = 0, start_addr;
   logic start, rd_halted, rd_timeout, busy, batch_done;
   logic [CW-1:0] rd_cycles;

   prog_run_sequencer #(.NUM_PROGS(N), .ADDR_W(AW), .CNT_W(CW), .TIMEOUT_CYCLES(TO)) dut (
      .CLK(CLK), .Reset(Reset), .go(go), .wr_en(wr_en), .wr_idx(wr_idx), .wr_addr(wr_addr),
      .rd_idx(rd_idx), .start(start), .start_addr(start_addr), .done(done), .halt(halt),
      .rd_cycles(rd_cycles), .rd_halted(rd_halted), .rd_timeout(rd_timeout),
      .busy(busy), .batch_done(batch_done));

   always #5 CLK = ~CLK;

   int checks = 0, failures = 0, n_start = 0;
   logic e_start = 0, e_busy = 0, e_bd = 0, e_av = 0, chk_en = 0, fin = 0, poke = 0;
   logic [AW-1:0] e_addr = 0;
   logic [AW-1:0] tbl [N];
   bit dl [N][ML];
   bit hl [N][ML];
   int ek [N];
   bit eh [N], et [N];

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge CLK) if (chk_en) begin
      chk("start", int'(start), int'(e_start));
      chk("busy", int'(busy), int'(e_busy));
      chk("batch_done", int'(batch_done), int'(e_bd));
      if (e_av) chk("start_addr", int'(start_addr), int'(e_addr));
      if (start) n_start++;
   end

   // completion = first RUN cycle j whose done level rises versus the previous cycle (LAUNCH is cycle 0)
   function automatic void model(input int s);
      ek[s] = 0; eh[s] = 0; et[s] = 0;
      for (int j = 1; j < ML && ek[s] == 0; j++) begin
         if (hl[s][j]) eh[s] = 1;
         if (dl[s][j] && !dl[s][j-1]) ek[s] = j;
         else if (j == TO) begin ek[s] = j; et[s] = 1; end
      end
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic cyc(input bit g, input bit d, input bit h, input bit bw,
                      input bit s, input bit b, input bit bd, input bit av, input logic [AW-1:0] a);
      go = g; done = d; halt = h;
      wr_en = bw ? rb() : 1'b0; wr_idx = 2'($urandom); wr_addr = 8'($urandom);
      if (bw && poke) begin wr_en = 1; wr_idx = 0; wr_addr = 8'h55; poke = 0; end
      e_start = s; e_busy = b; e_bd = bd; e_av = av; e_addr = a;
      @(posedge CLK); #1;
   endtask

   task automatic wr(input int i, input logic [AW-1:0] a);
      go = 0; done = 0; halt = 0; wr_en = 1; wr_idx = 2'(i); wr_addr = a;
      e_start = 0; e_busy = 0; e_bd = fin; e_av = 0;
      @(posedge CLK); #1;
      wr_en = 0;
      if (i < N) tbl[i] = a;
   endtask

   task automatic run_batch(input int stop_slot);
      cyc(1, 0, 0, 0, 0, 0, fin, 0, 0);
      fin = 0;
      for (int s = 0; s < N; s++) begin
         model(s);
         if (ek[s] == 0) chk("model_has_edge", 0, 1);
         cyc(rb(), dl[s][0], rb(), 1, 1, 1, 0, 1, tbl[s]);
         for (int j = 1; j <= ek[s]; j++) begin
            if (s == stop_slot && j == 4) return;
            cyc(rb(), dl[s][j], hl[s][j], 1, 0, 1, 0, 1, tbl[s]);
         end
         cyc(rb(), dl[s][ek[s]], rb(), 1, 0, 1, 0, 0, 0);
      end
      fin = 1;
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic read_slot(input int i, input bit zero, input string tag);
      @(negedge CLK); rd_idx = 2'(i); #1;
      chk($sformatf("%s rd_cycles[%0d]", tag, i), int'(rd_cycles), (i < N && !zero) ? ek[i] : 0);
      chk($sformatf("%s rd_halted[%0d]", tag, i), int'(rd_halted), (i < N && !zero) ? int'(eh[i]) : 0);
      chk($sformatf("%s rd_timeout[%0d]", tag, i), int'(rd_timeout), (i < N && !zero) ? int'(et[i]) : 0);
   endtask

   task automatic check_results(input bit zero);
      for (int i = 0; i < 4; i++) read_slot(i, zero, "res");
      @(posedge CLK); #1;
   endtask

   task automatic lit(input int i, input int c, input bit h, input bit t);
      @(negedge CLK); rd_idx = 2'(i); #1;
      chk($sformatf("lit rd_cycles[%0d]", i), int'(rd_cycles), c);
      chk($sformatf("lit rd_halted[%0d]", i), int'(rd_halted), int'(h));
      chk($sformatf("lit rd_timeout[%0d]", i), int'(rd_timeout), int'(t));
      @(posedge CLK); #1;
   endtask

   task automatic gen(input int s);
      int r;
      for (int j = 0; j < ML; j++) begin
         dl[s][j] = ($urandom_range(0, 5) == 0);
         hl[s][j] = ($urandom_range(0, 15) == 0);
      end
      if (rb()) begin
         r = $urandom_range(0, 8);
         for (int j = 0; j <= r; j++) dl[s][j] = 1;
      end
      dl[s][ML-2] = 0; dl[s][ML-1] = 1;
   endtask

   task automatic rise(input int s, input int k);
      for (int j = 0; j < ML; j++) begin dl[s][j] = (j >= k); hl[s][j] = 0; end
   endtask

   initial begin
      #5_000_000;
      failures++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      for (int i = 0; i < N; i++) tbl[i] = 0;
      #2;
      chk("reset start", int'(start), 0);
      chk("reset busy", int'(busy), 0);
      chk("reset batch_done", int'(batch_done), 0);
      chk("reset start_addr", int'(start_addr), 0);
      chk("reset rd_cycles", int'(rd_cycles), 0);
      #10 Reset = 0;
      @(posedge CLK); #1;
      chk_en = 1;
      // directed batch: addresses 0,75,0 with done rising at 20,35,5
      wr(0, 0); wr(1, 75); wr(2, 0); wr(3, 8'hAA);
      rise(0, 20); rise(1, 35); rise(2, 5);
      run_batch(-1);
      chk("start pulses", n_start, 3);
      chk("batch_done after batch", int'(batch_done), 1);
      lit(0, 20, 0, 0); lit(1, 35, 0, 0); lit(2, 5, 0, 0);
      check_results(0);
      // held done across LAUNCH, halt pulse in slot 1, write attempted while busy
      rise(0, 7); rise(1, 10); rise(2, 12);
      for (int j = 0; j < 3; j++) dl[1][j] = 1;
      hl[1][4] = 1;
      poke = 1;
      run_batch(-1);
      chk("start pulses 2", n_start, 6);
      lit(0, 7, 0, 0); lit(1, 10, 1, 0); lit(2, 12, 0, 0);
      check_results(0);
      // random batches; go and wr_en toggle randomly while busy
      for (int b = 0; b < 6; b++) begin
         if (b % 2 == 0) for (int i = 0; i < 4; i++) wr(i, 8'($urandom));
         for (int s = 0; s < N; s++) gen(s);
         run_batch(-1);
         check_results(0);
      end
`ifdef SEQ_TIMEOUT_EN
      for (int j = 0; j < ML; j++) begin dl[0][j] = 0; hl[0][j] = 0; end
      gen(1); gen(2);
      run_batch(-1);
      lit(0, 100, 0, 1);
      check_results(0);
`endif
      // reset during RUN of slot 1
      gen(0); rise(1, 30); gen(2);
      run_batch(1);
      chk_en = 0;
      #1 Reset = 1;
      e_start = 0; e_busy = 0; e_bd = 0; e_av = 0;
      #1;
      chk("async reset start", int'(start), 0);
      chk("async reset busy", int'(busy), 0);
      chk("async reset batch_done", int'(batch_done), 0);
      for (int i = 0; i < N; i++) begin
         rd_idx = 2'(i); #1;
         chk($sformatf("async reset rd_cycles[%0d]", i), int'(rd_cycles), 0);
      end
      go = 0; wr_en = 0; done = 0; halt = 0;
      @(negedge CLK) Reset = 0;
      for (int i = 0; i < N; i++) tbl[i] = 0;
      fin = 0;
      @(posedge CLK); #1;
      chk_en = 1;
      check_results(1);
      for (int s = 0; s < N; s++) gen(s);
      run_batch(-1);
      check_results(0);
      chk_en = 0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
